// File: rtl/pcs_rx_word_align.sv
// Receive 10-bit symbol aligner: comma search over all bit offsets plus sync FSM.
// Optional statistics outputs are enabled with `define PCS_RX_ALIGN_STATS_EN.
module pcs_rx_word_align #(
    parameter int ACQ_COMMAS = 3,
    parameter int LOSS_BAD   = 4,
    parameter int GOOD_RUN   = 4,
    parameter int MAX_GAP    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [9:0]  rx_10b_raw,
    output logic        out_valid,
    output logic [9:0]  out_10b,
    output logic        out_comma,
    output logic        sync_ok,
    output logic [3:0]  align_offset,
    output logic        realign
`ifdef PCS_RX_ALIGN_STATS_EN
    ,
    output logic [15:0] loss_cnt,
    output logic [15:0] bad_cnt_total
`endif
);

    localparam int CW = $clog2(ACQ_COMMAS + 1);
    localparam int BW = $clog2(LOSS_BAD + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);
    localparam int XW = $clog2(MAX_GAP + 1);

    localparam logic [CW-1:0] CMAX = CW'(ACQ_COMMAS);
    localparam logic [BW-1:0] BMAX = BW'(LOSS_BAD);
    localparam logic [GW-1:0] GRUN = GW'(GOOD_RUN);
    localparam logic [XW-1:0] XMAX = XW'(MAX_GAP);

    typedef enum logic [1:0] {
        S_LOSS,
        S_ACQ,
        S_SYNC
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    offset_q, offset_d;
    logic [9:0]    prev_q, prev_d;
    logic [CW-1:0] comma_q, comma_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [GW-1:0] good_q, good_d;
    logic [XW-1:0] gap_q, gap_d;

    logic          out_valid_q, out_valid_d;
    logic [9:0]    out_10b_q, out_10b_d;
    logic          out_comma_q, out_comma_d;
    logic          sync_ok_q, sync_ok_d;
    logic          realign_q, realign_d;

    logic [19:0]   win;
    logic [9:0]    cand [10];
    logic [9:0]    hit;
    logic [3:0]    first_k;
    logic          any_hit;
    logic          lock_hit;
    logic          bad_word;

    // Candidate k starts k bits into the 20-bit window; lowest k wins.
    always_comb begin
        win     = {prev_q, rx_10b_raw};
        first_k = 4'd0;
        for (int k = 0; k < 10; k++) begin
            cand[k] = win[19-k -: 10];
            hit[k]  = (cand[k][9:3] == 7'b0011111) ||
                      (cand[k][9:3] == 7'b1100000);
        end
        for (int k = 9; k >= 0; k--) begin
            if (hit[k]) first_k = 4'(k);
        end
    end

    assign any_hit  = |hit;
    assign lock_hit = hit[offset_q];
    assign bad_word = any_hit && !lock_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOSS;
            offset_q <= 4'd0;
            prev_q   <= 10'd0;
            comma_q  <= '0;
            bad_q    <= '0;
            good_q   <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            prev_q   <= prev_d;
            comma_q  <= comma_d;
            bad_q    <= bad_d;
            good_q   <= good_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        prev_d   = prev_q;
        comma_d  = comma_q;
        bad_d    = bad_q;
        good_d   = good_q;
        gap_d    = gap_q;
        if (rx_valid) begin
            prev_d = rx_10b_raw;
            unique case (state_q)
                S_LOSS: begin
                    if (any_hit) begin
                        state_d  = S_ACQ;
                        offset_d = first_k;
                        comma_d  = CW'(1);
                        gap_d    = '0;
                    end
                end
                S_ACQ: begin
                    if (lock_hit) begin
                        gap_d = '0;
                        if (comma_q != CMAX) comma_d = comma_q + 1'b1;
                        if (comma_d == CMAX) begin
                            state_d = S_SYNC;
                            bad_d   = '0;
                            good_d  = '0;
                        end
                    end else if (any_hit) begin
                        state_d = S_LOSS;
                    end else begin
                        if (gap_q != XMAX) gap_d = gap_q + 1'b1;
                        if (gap_d == XMAX) state_d = S_LOSS;
                    end
                end
                S_SYNC: begin
                    if (bad_word) begin
                        good_d = '0;
                        if (bad_q != BMAX) bad_d = bad_q + 1'b1;
                        if (bad_d == BMAX) state_d = S_LOSS;
                    end else begin
                        if (good_q != GRUN) good_d = good_q + 1'b1;
                        if (good_d == GRUN) begin
                            good_d = '0;
                            if (bad_q != '0) bad_d = bad_q - 1'b1;
                        end
                    end
                end
                default: state_d = S_LOSS;
            endcase
        end
    end

    // offset_d already carries a newly chosen boundary, so the comma word
    // itself leaves aligned.
    always_comb begin
        out_valid_d = rx_valid;
        out_10b_d   = out_10b_q;
        out_comma_d = out_comma_q;
        if (rx_valid) begin
            out_10b_d   = cand[offset_d];
            out_comma_d = hit[offset_d];
        end
        realign_d = (offset_d != offset_q);
        sync_ok_d = (state_d == S_SYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_10b_q   <= 10'd0;
            out_comma_q <= 1'b0;
            sync_ok_q   <= 1'b0;
            realign_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_10b_q   <= out_10b_d;
            out_comma_q <= out_comma_d;
            sync_ok_q   <= sync_ok_d;
            realign_q   <= realign_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_10b      = out_10b_q;
    assign out_comma    = out_comma_q;
    assign sync_ok      = sync_ok_q;
    assign align_offset = offset_q;
    assign realign      = realign_q;

`ifdef PCS_RX_ALIGN_STATS_EN
    logic [15:0] loss_q, loss_d;
    logic [15:0] badt_q, badt_d;

    always_comb begin
        loss_d = loss_q;
        badt_d = badt_q;
        if (rx_valid && state_q == S_SYNC) begin
            if (state_d == S_LOSS && loss_q != 16'hFFFF) loss_d = loss_q + 1'b1;
            if (bad_word && badt_q != 16'hFFFF) badt_d = badt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= 16'd0;
            badt_q <= 16'd0;
        end else begin
            loss_q <= loss_d;
            badt_q <= badt_d;
        end
    end

    assign loss_cnt      = loss_q;
    assign bad_cnt_total = badt_q;
`endif

endmodule

// File: tb/tb_pcs_rx_word_align.sv
// Directed testbench for pcs_rx_word_align.
module tb_pcs_rx_word_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [9:0]  rx_10b_raw;
    logic        out_valid;
    logic [9:0]  out_10b;
    logic        out_comma;
    logic        sync_ok;
    logic [3:0]  align_offset;
    logic        realign;
`ifdef PCS_RX_ALIGN_STATS_EN
    logic [15:0] loss_cnt;
    logic [15:0] bad_cnt_total;
`endif

    int checks = 0;
    int errors = 0;

    // K28.5-, D21.5, and a pair (A,B) that forms a comma only at offset 7
    localparam logic [9:0] K = 10'h0FA;
    localparam logic [9:0] D = 10'h2AA;
    localparam logic [9:0] A = 10'h2A6;
    localparam logic [9:0] B = 10'h02A;
    localparam logic [9:0] C7 = 10'h305;

    logic [17:0] obs;
    assign obs = {out_valid, out_10b, out_comma, sync_ok, align_offset, realign};

    pcs_rx_word_align dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_10b_raw   (rx_10b_raw),
        .out_valid    (out_valid),
        .out_10b      (out_10b),
        .out_comma    (out_comma),
        .sync_ok      (sync_ok),
        .align_offset (align_offset),
        .realign      (realign)
`ifdef PCS_RX_ALIGN_STATS_EN
        ,
        .loss_cnt     (loss_cnt),
        .bad_cnt_total(bad_cnt_total)
`endif
    );

    always #5 clk = ~clk;

    task automatic send(input logic [9:0] w);
        rx_valid   = 1'b1;
        rx_10b_raw = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_10b_raw = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 18'd0) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, 18'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_aligned();
        logic [9:0]  w  [8] = '{K, D, K, D, K, D, K, D};
        logic [9:0]  eo [8] = '{10'h000, K, D, K, D, K, D, K};
        logic [7:0]  ec = 8'b1010_1010;
        logic [7:0]  es = 8'b1110_0000;
        logic [17:0] ex;
        for (int i = 0; i < 8; i++) begin
            send(w[i]);
            ex = {1'b1, eo[i], ec[i], es[i], 4'd0, 1'b0};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL aligned[%0d]: got %h expected %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_bad_decay();
        logic [9:0]  q [$];
        logic [9:0]  pw = D;
        logic [17:0] ex;
        repeat (3) begin q.push_back(A); q.push_back(B); end
        repeat (12) q.push_back(D);
        repeat (3) begin q.push_back(A); q.push_back(B); end
        repeat (12) q.push_back(D);
        foreach (q[i]) begin
            send(q[i]);
            ex = {1'b1, pw, 1'b0, 1'b1, 4'd0, 1'b0};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL bad_decay[%0d]: got %h expected %h", i, obs, ex);
            end
            pw = q[i];
        end
    endtask

    task automatic test_sync_loss();
        logic [9:0]  w  [10] = '{A, B, A, B, A, B, A, B, A, B};
        logic [9:0]  eo [10] = '{D, A, B, A, B, A, B, A, B, C7};
        logic [9:0]  es = 10'b00_0111_1111;
        logic [17:0] ex;
        for (int i = 0; i < 10; i++) begin
            send(w[i]);
            if (i == 9) ex = {1'b1, C7, 1'b1, 1'b0, 4'd7, 1'b1};
            else ex = {1'b1, eo[i], 1'b0, es[i], 4'd0, 1'b0};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL sync_loss[%0d]: got %h expected %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_gap_edge();
        logic [17:0] ex;
        repeat (62) send(D);
        send(A);
        checks++;
        if ({sync_ok, align_offset, realign} !== {1'b0, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL gap63: got %b/%0d/%b expected 0/7/0",
                     sync_ok, align_offset, realign);
        end
        send(B);
        ex = {1'b1, C7, 1'b1, 1'b0, 4'd7, 1'b0};
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL gap_comma2: got %h expected %h", obs, ex);
        end
        send(A);
        send(B);
        ex = {1'b1, C7, 1'b1, 1'b1, 4'd7, 1'b0};
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL gap_sync7: got %h expected %h", obs, ex);
        end
    endtask

    task automatic test_acq_timeout();
        logic [17:0] ex;
        for (int i = 0; i < 4; i++) begin
            send(K);
            send(D);
            checks++;
            if ({sync_ok, align_offset, realign} !== {(i != 3), 4'd7, 1'b0}) begin
                errors++;
                $display("FAIL bad_at0[%0d]: got %b/%0d/%b expected %b/7/0",
                         i, sync_ok, align_offset, realign, i != 3);
            end
        end
        send(K);
        send(D);
        ex = {1'b1, K, 1'b1, 1'b0, 4'd0, 1'b1};
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL relock0: got %h expected %h", obs, ex);
        end
        send(K);
        send(D);
        ex = {1'b1, K, 1'b1, 1'b0, 4'd0, 1'b0};
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL acq_comma2: got %h expected %h", obs, ex);
        end
        for (int i = 0; i < 64; i++) begin
            send(D);
            checks++;
            if (sync_ok !== 1'b0) begin
                errors++;
                $display("FAIL gap_run[%0d]: sync_ok got %b expected 0", i, sync_ok);
            end
        end
        for (int i = 0; i < 3; i++) begin
            send(K);
            send(D);
            ex = {1'b1, K, 1'b1, (i == 2), 4'd0, 1'b0};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL after_timeout[%0d]: got %h expected %h", i, obs, ex);
            end
        end
`ifdef PCS_RX_ALIGN_STATS_EN
        checks++;
        if ({loss_cnt, bad_cnt_total} !== {16'd2, 16'd14}) begin
            errors++;
            $display("FAIL stats: got %0d/%0d expected 2/14", loss_cnt, bad_cnt_total);
        end
`endif
    endtask

    task automatic test_shift3();
        logic [9:0]  w  [7] = '{10'h01F, 10'h155, 10'h11F, 10'h155,
                                10'h11F, 10'h155, 10'h11F};
        logic [9:0]  eo [7] = '{10'h000, K, D, K, D, K, D};
        logic [6:0]  ec = 7'b010_1010;
        logic [6:0]  es = 7'b110_0000;
        logic [6:0]  er = 7'b000_0010;
        logic [17:0] ex;
        rst = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(w[i]);
            ex = {1'b1, eo[i], ec[i], es[i], (i == 0) ? 4'd0 : 4'd3, er[i]};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL shift3[%0d]: got %h expected %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_valid_gap();
        logic [17:0] ex;
        rx_valid = 1'b0;
        ex = {1'b0, D, 1'b0, 1'b1, 4'd3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL valid_gap[%0d]: got %h expected %h", i, obs, ex);
            end
        end
        send(10'h155);
        ex = {1'b1, K, 1'b1, 1'b1, 4'd3, 1'b0};
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL valid_resume: got %h expected %h", obs, ex);
        end
    endtask

    task automatic test_mid_reset();
        logic [17:0] ex;
        rst        = 1'b1;
        rx_valid   = 1'b1;
        rx_10b_raw = 10'h11F;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected %h", obs, 18'd0);
        end
        rst = 1'b0;
        send(10'h155);
        ex = {1'b1, 10'h000, 1'b0, 1'b0, 4'd0, 1'b0};
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL post_reset: got %h expected %h", obs, ex);
        end
    endtask

    initial begin
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_10b_raw = 10'd0;
        test_reset();
        test_aligned();
        test_bad_decay();
        test_sync_loss();
        test_gap_edge();
        test_acq_timeout();
        test_shift3();
        test_valid_gap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcs_rx_word_align.md
Name: pcs_rx_word_align

Overview:
- Receive-side 10-bit symbol aligner. It sits directly downstream of the 8b/10b TX data path in the loopback/serial path, and directly upstream of the 10b/8b decoder.
- Takes an arbitrarily bit-shifted 10-bit word stream, searches for the comma in every bit offset, and locks the symbol boundary.
- Runs a simplified 802.3 clause-36 sync FSM and delivers aligned code-groups plus sync status to the decoder.

Parameters:
- ACQ_COMMAS, 3, consecutive commas at the locked offset required to declare sync.
- LOSS_BAD, 4, bad-event count that drops sync.
- GOOD_RUN, 4, consecutive good words that decrement the bad count by 1.
- MAX_GAP, 64, words allowed without a comma during acquisition before returning to LOSS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  rx_10b_raw carries a word this cycle.
- rx_10b_raw  in  10  unaligned word; bit 9 = first-received bit ('a').
- out_valid  out  1  out_10b valid.
- out_10b  out  10  aligned code-group, bit 9 = 'a'.
- out_comma  out  1  out_10b carries a comma at the locked boundary.
- sync_ok  out  1  sync acquired.
- align_offset  out  4  current boundary offset, 0..9.
- realign  out  1  one-cycle pulse when align_offset changes.

Behaviour:
- Reset: all outputs 0; prev word = 0; state LOSS; all counters 0.
- Window:
  - W = {prev, rx_10b_raw}, 20 bits.
  - Candidate k (k = 0..9) = W[19-k -: 10].
  - Comma at k: candidate[9:3] == 7'b0011111 or 7'b1100000.
- Words are processed only when rx_valid = 1. Otherwise all state holds and out_valid = 0 next cycle.
- Accepting a word updates prev <= rx_10b_raw.
- Latency is 1 clk. out_10b = candidate at the effective offset, registered.
- Effective offset: the new offset when one is chosen on that word, so the comma word itself is emitted aligned with out_comma = 1. Otherwise it is the held offset.
- Multiple comma hits in one window: lowest k wins.
- States:
  - LOSS:
    - Comma at any k -> ACQ: offset <= k, comma_cnt = 1, gap = 0.
    - Pulse realign if k differs from the old offset.
  - ACQ:
    - Comma at the locked offset: comma_cnt++, gap = 0. When comma_cnt reaches ACQ_COMMAS -> SYNC, bad = 0, good = 0.
    - Comma only at another offset -> LOSS.
    - No comma: gap++. Reaching MAX_GAP -> LOSS.
  - SYNC:
    - Bad word = comma present at another offset and not at the locked one: bad++, good = 0.
    - Any other word: good++. When good reaches GOOD_RUN: good = 0, and bad decrements if nonzero.
    - bad reaching LOSS_BAD -> LOSS.
    - Offset is frozen in SYNC.
- sync_ok = 1 exactly while in SYNC, registered. It rises in the cycle the ACQ_COMMAS-th comma is emitted.
- Entering LOSS from ACQ or SYNC keeps the old offset until a new comma is found.
- Counters saturate and never wrap. gap is 7 bits for the default MAX_GAP.
- A mid-stream rst returns to LOSS within the same edge.

Optional Feature:
- Macro: PCS_RX_ALIGN_STATS_EN.
- With the macro defined:
  - Adds outputs loss_cnt (16-bit) and bad_cnt_total (16-bit).
  - loss_cnt increments on each SYNC -> LOSS transition.
  - bad_cnt_total increments on each SYNC bad word.
  - Both saturate at 0xFFFF and clear on rst.
- Without the macro: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Aligned stream, repeating K28.5- 0x0FA then D21.5 0x2AA, offset 0 -> align_offset = 0, realign never pulses, sync_ok = 1 on the 3rd comma output, out_10b mirrors input delayed 1 clk.
- Same stream bit-shifted by 3 -> first comma output is 0x0FA with out_comma = 1, align_offset = 3, realign pulses once, sync_ok after the 3rd comma.
- In SYNC, inject 4 commas at offset 7 spaced 2 words apart -> sync_ok drops after the 4th. The next comma at offset 7 re-locks with align_offset = 7 and realign pulses.
- In SYNC: 3 bad commas, then 12 good words, then 3 bad commas -> bad count goes 3 -> 0 -> 3, and sync_ok stays 1.
- In ACQ after 2 commas, send 64 D21.5 words -> return to LOSS, sync_ok stays 0.
- rx_valid low for 5 cycles mid-stream -> out_valid = 0, state and outputs hold. rst asserted mid-SYNC -> all outputs 0 next clk.
